// File: rtl/lstm_output_packer.sv
// Packs pairs of 16-bit LSTM samples into 32-bit AXI4-Stream beats, framed with
// TLAST, buffered through a FIFO, with a sticky overflow flag for dropped beats.
module lstm_output_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRAME_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   y_in,
  input  logic                          y_in_valid,
  input  logic                          flush,
  output logic [31:0]                   m_axis_tdata,
  output logic [3:0]                    m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = $clog2(FRAME_LEN);
  localparam logic [SW-1:0] S_LAST  = SW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] S_ONE   = SW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  // Sample counter and pending even half
  logic [SW-1:0] cnt_q, cnt_d;
  logic [15:0]   pend_q, pend_d;

  // Beat produced this cycle (at most one)
  logic          push;
  logic [31:0]   push_data;
  logic [3:0]    push_keep;
  logic          push_last;

  // FIFO state
  logic [36:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic          empty, full, pop, accept;
  logic [36:0]   head;

  // Packing: odd counter value means an even sample is waiting in pend_q.
  // A flush closes the frame after the current sample has been applied.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_keep = '0;
    push_last = 1'b0;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    if (y_in_valid) begin
      if (!cnt_q[0]) begin
        pend_d = y_in;
        if (flush) begin
          push      = 1'b1;
          push_data = {16'h0000, y_in};
          push_keep = 4'h3;
          push_last = 1'b1;
        end
      end else begin
        push      = 1'b1;
        push_data = {y_in, pend_q};
        push_keep = 4'hF;
        push_last = (cnt_q == S_LAST) || flush;
      end
      cnt_d = (cnt_q == S_LAST) ? '0 : cnt_q + S_ONE;
    end else if (flush && cnt_q[0]) begin
      push      = 1'b1;
      push_data = {16'h0000, pend_q};
      push_keep = 4'h3;
      push_last = 1'b1;
    end
    if (flush) cnt_d = '0;
  end

  // Packer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop    = m_axis_tvalid && m_axis_tready;
  // When full, the write slot is the head being popped, so the overwrite is safe.
  assign accept = push && (!full || pop);
  assign head   = mem_q[rd_q[AW-1:0]];

  // Outputs come straight from stored registers, forced to zero when empty.
  always_comb begin
    m_axis_tvalid = !empty;
    m_axis_tdata  = empty ? '0 : head[36:5];
    m_axis_tkeep  = empty ? '0 : head[4:1];
    m_axis_tlast  = empty ? 1'b0 : head[0];
  end

  assign fifo_level = level_q;
  assign overflow   = overflow_q;

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q[AW-1:0]] <= {push_data, push_keep, push_last};
  end

  // FIFO pointers, level and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_q <= wr_q + PTR_ONE;
      if (pop)    rd_q <= rd_q + PTR_ONE;
      if (accept && !pop)      level_q <= level_q + PTR_ONE;
      else if (!accept && pop) level_q <= level_q - PTR_ONE;
      if (push && !accept) overflow_q <= 1'b1;
    end
  end

endmodule
